muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle M-extension execution unit for the RV32IM EX stage.
- Takes RV32M operations (ALU_OP bit0 = 1) off the single-cycle ALU.
- Sequences an iterative 32-step shift-add multiplier and a restoring divider.
- Holds the pipeline with STALL until the result is ready, then presents it to the EX/MEM register for one cycle.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  EX stage holds a valid instruction.
- ALU_OP  input  5  control-unit ALU op. M encodings: MUL 00001, MULH 00101, MULHSU 01101, MULHU 01001, DIV 10001, DIVU 10101, REM 11001, REMU 11101.
- DATA1  input  WIDTH  rs1 operand.
- DATA2  input  WIDTH  rs2 operand.
- FLUSH  input  1  EX-stage kill (branch/jump redirect).
- STALL  output  1  freeze PC, IF/ID and ID/EX registers.
- BUSY  output  1  sequencer is not in IDLE.
- RESULT  output  WIDTH  rd value.
- RESULT_VALID  output  1  RESULT is valid this cycle.

Behaviour:
- Engagement: engage = START & ALU_OP[0] & ~FLUSH, sampled in IDLE only. Non-M ops never engage; STALL stays low for them.
- States: IDLE, MUL_RUN, DIV_RUN, SIGN_FIX, DONE.
- Reset (RESET low, asynchronous) sets:
  - state to IDLE;
  - STALL, BUSY and RESULT_VALID to 0;
  - RESULT to 0;
  - iteration counter and internal registers to 0.
- IDLE, on engage:
  - latch ALU_OP, operand magnitudes and sign flags (signed: MUL/MULH/DIV/REM both operands; MULHSU rs1 only);
  - load counter with 31;
  - go to MUL_RUN (ALU_OP[4] = 0) or DIV_RUN (ALU_OP[4] = 1).
- Special divide cases, when FAST_SPECIAL = 1: decided in IDLE, which goes straight to DONE with the result loaded.
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give DATA1.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
  - When FAST_SPECIAL = 0, these cases iterate and SIGN_FIX forces the same values.
- MUL_RUN: one unsigned shift-add step per cycle into a 64-bit accumulator. Counter decrements; at counter = 0 go to SIGN_FIX.
- DIV_RUN: one restoring-division step per cycle, using unsigned magnitudes. Counter decrements; at counter = 0 go to SIGN_FIX.
- SIGN_FIX:
  - Product: negate the 64-bit product if the sign flags differ. MUL selects [31:0]; MULH/MULHSU/MULHU select [63:32].
  - Quotient: negate if the signs differ (DIV).
  - Remainder: takes the dividend's sign (REM).
  - Load RESULT, then go to DONE.
- DONE:
  - RESULT_VALID = 1 for exactly one cycle; RESULT holds its value until the next load.
  - Unconditionally return to IDLE. START is ignored in DONE, because the same instruction is still in EX.
- STALL, combinational:
  - 1 in IDLE when engage;
  - 1 in MUL_RUN, DIV_RUN and SIGN_FIX;
  - 0 in DONE, which lets the pipeline advance.
- BUSY = state != IDLE.
- Latency, measured from the START cycle to the RESULT_VALID cycle: iterative path 34 cycles; special path 1 cycle. STALL is high for 34 cycles and 1 cycle respectively.
- FLUSH:
  - In any non-IDLE state, go to IDLE next edge.
  - No RESULT_VALID; RESULT is unchanged.
  - STALL is forced low in the FLUSH cycle.
- Back-to-back M ops: the second instruction's START arrives in the cycle after DONE, in IDLE, with no gap penalty.
- Operands are latched at engage; DATA1/DATA2 changes during RUN have no effect.

Test Plan:
- Reset with RESET = 0 mid DIV_RUN (counter = 12) → immediately IDLE; STALL = BUSY = RESULT_VALID = 0; RESULT = 0.
- MUL 7 × 0xFFFFFFFD → STALL high for 34 cycles; RESULT_VALID on cycle 34 with RESULT = 0xFFFFFFEB. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → RESULT_VALID 1 cycle after START with 0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- FLUSH on cycle 10 of MUL_RUN → STALL low that cycle; IDLE next; no RESULT_VALID. ADD op (ALU_OP 00000) with START = 1 → STALL never asserted.
- Back-to-back MUL 3 × 4 then DIV 12 / 4 → RESULT_VALID pulses with 12 then 3; the second START is taken in the cycle after the first DONE.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the EX stage and the M-extension sequencer.
// The EX stage drives the master side. The sequencer sits on the slave side.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
) ();
   logic             START;
   logic [4:0]       ALU_OP;
   logic [WIDTH-1:0] DATA1;
   logic [WIDTH-1:0] DATA2;
   logic             FLUSH;
   logic             STALL;
   logic             BUSY;
   logic [WIDTH-1:0] RESULT;
   logic             RESULT_VALID;

   modport master (
      output START, ALU_OP, DATA1, DATA2, FLUSH,
      input  STALL, BUSY, RESULT, RESULT_VALID
   );

   modport slave (
      input  START, ALU_OP, DATA1, DATA2, FLUSH,
      output STALL, BUSY, RESULT, RESULT_VALID
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execution unit: a 32-step shift-add multiplier and a restoring divider.
// The unit stalls the pipeline until the result is ready.
module muldiv_sequencer #(
   parameter int WIDTH        = 32,
   parameter bit FAST_SPECIAL = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_RUN, SIGN_FIX, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [2:0]       op_r;          // ALU_OP[4:2]: {is_div, op bit3, op bit2}
   logic             neg_a, neg_b, div_zero;
   logic [WIDTH-1:0] opnd;          // multiplicand or divisor magnitude
   logic [WIDTH-1:0] hi, lo;        // product accumulator, or remainder and quotient
   logic [WIDTH-1:0] result_r;
   logic             result_valid_r;

   logic             engage, is_div, sgn1, sgn2, neg1, neg2, zero_div, ovf;
   logic [WIDTH-1:0] mag1, mag2, special_val;

   always_comb begin
      engage   = bus.START & bus.ALU_OP[0] & ~bus.FLUSH;
      is_div   = bus.ALU_OP[4];
      sgn1     = 1'b0;
      sgn2     = 1'b0;
      if (is_div) begin
         sgn1 = ~bus.ALU_OP[2];
         sgn2 = ~bus.ALU_OP[2];
      end else begin
         sgn1 = (bus.ALU_OP[3:2] != 2'b10);
         sgn2 = ~bus.ALU_OP[3];
      end
      neg1     = sgn1 & bus.DATA1[WIDTH-1];
      neg2     = sgn2 & bus.DATA2[WIDTH-1];
      mag1     = neg1 ? -bus.DATA1 : bus.DATA1;
      mag2     = neg2 ? -bus.DATA2 : bus.DATA2;
      zero_div = is_div & (bus.DATA2 == '0);
      ovf      = is_div & ~bus.ALU_OP[2] & (bus.DATA1 == MIN_NEG) & (bus.DATA2 == '1);
      if (bus.ALU_OP[3])
         special_val = zero_div ? bus.DATA1 : '0;
      else
         special_val = zero_div ? '1 : MIN_NEG;
   end

   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     mul_sum, div_trial, div_diff;
   logic               take;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quot_s, rem_s, fix_val;

   always_comb begin
      addend    = lo[0] ? opnd : '0;
      mul_sum   = {1'b0, hi} + {1'b0, addend};
      div_trial = {hi, lo[WIDTH-1]};
      div_diff  = div_trial - {1'b0, opnd};
      take      = (div_trial >= {1'b0, opnd});
      prod      = {hi, lo};
      prod_s    = (neg_a ^ neg_b) ? -prod : prod;
      quot_s    = (neg_a ^ neg_b) ? -lo : lo;
      rem_s     = neg_a ? -hi : hi;
      fix_val   = '0;
      if (op_r[2]) begin
         // A zero divisor iterates to an all-ones magnitude. Force it so the sign flags cannot flip it.
         if (op_r[1])
            fix_val = rem_s;
         else
            fix_val = div_zero ? '1 : quot_s;
      end else begin
         fix_val = (op_r[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state          <= IDLE;
         cnt            <= '0;
         op_r           <= '0;
         neg_a          <= 1'b0;
         neg_b          <= 1'b0;
         div_zero       <= 1'b0;
         opnd           <= '0;
         hi             <= '0;
         lo             <= '0;
         result_r       <= '0;
         result_valid_r <= 1'b0;
      end else begin
         result_valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (engage) begin
                  op_r     <= bus.ALU_OP[4:2];
                  neg_a    <= neg1;
                  neg_b    <= neg2;
                  div_zero <= zero_div;
                  cnt      <= CW'(WIDTH - 1);
                  hi       <= '0;
                  opnd     <= is_div ? mag2 : mag1;
                  lo       <= is_div ? mag1 : mag2;
                  if (FAST_SPECIAL && (zero_div || ovf)) begin
                     result_r       <= special_val;
                     result_valid_r <= 1'b1;
                     state          <= DONE;
                  end else begin
                     state <= is_div ? DIV_RUN : MUL_RUN;
                  end
               end
            end
            MUL_RUN: begin
               if (bus.FLUSH) begin
                  state <= IDLE;
               end else begin
                  {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
                  cnt      <= cnt - CW'(1);
                  if (cnt == '0) state <= SIGN_FIX;
               end
            end
            DIV_RUN: begin
               if (bus.FLUSH) begin
                  state <= IDLE;
               end else begin
                  hi  <= take ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
                  lo  <= {lo[WIDTH-2:0], take};
                  cnt <= cnt - CW'(1);
                  if (cnt == '0) state <= SIGN_FIX;
               end
            end
            SIGN_FIX: begin
               if (bus.FLUSH) begin
                  state <= IDLE;
               end else begin
                  result_r       <= fix_val;
                  result_valid_r <= 1'b1;
                  state          <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.STALL = 1'b0;
      if (RESET && !bus.FLUSH) begin
         case (state)
            IDLE:                       bus.STALL = engage;
            MUL_RUN, DIV_RUN, SIGN_FIX: bus.STALL = 1'b1;
            default:                    bus.STALL = 1'b0;
         endcase
      end
   end

   assign bus.BUSY         = (state != IDLE);
   assign bus.RESULT       = result_r;
   assign bus.RESULT_VALID = result_valid_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer. It uses an arithmetic and timing model with directed vectors.
module tb_muldiv_sequencer;
   localparam logic [4:0] OP_MUL = 5'b00001, OP_MULH = 5'b00101, OP_MULHSU = 5'b01101,
                          OP_MULHU = 5'b01001, OP_DIV = 5'b10001, OP_DIVU = 5'b10101,
                          OP_REM = 5'b11001, OP_REMU = 5'b11101, OP_ADD = 5'b00000;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(32)) bus ();

   muldiv_sequencer #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [31:0] sa, sb;
      longint             sp;
      longint unsigned    up;
      sa = a;
      sb = b;
      ref_result = '0;
      case (op)
         OP_MUL:    begin sp = longint'(sa) * longint'(sb); ref_result = sp[31:0]; end
         OP_MULH:   begin sp = longint'(sa) * longint'(sb); ref_result = sp[63:32]; end
         OP_MULHSU: begin sp = longint'(sa) * longint'({32'h0, b}); ref_result = sp[63:32]; end
         OP_MULHU:  begin up = {32'h0, a} * {32'h0, b}; ref_result = up[63:32]; end
         OP_DIV:    ref_result = (b == 0) ? 32'hFFFF_FFFF :
                                 (a == MIN_NEG && b == 32'hFFFF_FFFF) ? MIN_NEG : 32'(sa / sb);
         OP_REM:    ref_result = (b == 0) ? a :
                                 (a == MIN_NEG && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
         OP_DIVU:   ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REMU:   ref_result = (b == 0) ? a : a % b;
         default:   ref_result = '0;
      endcase
   endfunction

   function automatic bit is_special(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
      return op[4] && (b == 0 || (!op[2] && a == MIN_NEG && b == 32'hFFFF_FFFF));
   endfunction

   // Model: an instruction stalls for 34 cycles (1 when special) and then shows its result for one cycle
   logic        m_active = 1'b0;
   logic        m_done   = 1'b0;
   int          m_left   = 0;
   logic [31:0] m_exp    = '0;
   logic [31:0] m_last   = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_left   <= 0;
         m_exp    <= '0;
         m_last   <= '0;
      end else if (!m_active) begin
         if (bus.START && bus.ALU_OP[0] && !bus.FLUSH) begin
            m_active <= 1'b1;
            m_exp    <= ref_result(bus.ALU_OP, bus.DATA1, bus.DATA2);
            if (is_special(bus.ALU_OP, bus.DATA1, bus.DATA2)) m_done <= 1'b1;
            else m_left <= 33;
         end
      end else if (m_done) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_last   <= m_exp;
      end else if (bus.FLUSH) begin
         m_active <= 1'b0;
      end else begin
         m_left <= m_left - 1;
         if (m_left == 1) m_done <= 1'b1;
      end
   end

   always @(negedge clk) begin
      logic exp_stall;
      if (!rst_n)        exp_stall = 1'b0;
      else if (!m_active) exp_stall = bus.START & bus.ALU_OP[0] & ~bus.FLUSH;
      else if (m_done)   exp_stall = 1'b0;
      else               exp_stall = ~bus.FLUSH;
      chk("stall", 32'(bus.STALL), 32'(exp_stall));
      chk("busy", 32'(bus.BUSY), 32'(m_active));
      chk("result_valid", 32'(bus.RESULT_VALID), 32'(m_done));
      chk("result", bus.RESULT, m_done ? m_exp : m_last);
   end

   task automatic go(input string nm, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lit, input int lat);
      int n;
      @(posedge clk); #1;
      bus.START = 1'b1; bus.ALU_OP = op; bus.DATA1 = a; bus.DATA2 = b;
      n = 0;
      @(negedge clk);
      while (!bus.RESULT_VALID && n < 60) begin
         if (n == 5) begin
            bus.DATA1 = 32'hDEAD_BEEF;
            bus.DATA2 = 32'h0000_0003;
         end
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, 32'(n), 32'(lat));
      chk({nm, " value"}, bus.RESULT, lit);
   endtask

   task automatic idle(input int k);
      @(posedge clk); #1;
      bus.START = 1'b0; bus.ALU_OP = OP_ADD; bus.FLUSH = 1'b0;
      repeat (k) @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int seen;
      bus.START = 1'b0; bus.ALU_OP = OP_ADD; bus.DATA1 = '0; bus.DATA2 = '0; bus.FLUSH = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset stall", 32'(bus.STALL), 32'h0);
      chk("reset busy", 32'(bus.BUSY), 32'h0);
      chk("reset result", bus.RESULT, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      go("MUL",     OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      go("MULH",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      go("MULHSU",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      go("MULHU",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      idle(2);
      go("DIV",     OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
      go("REM",     OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
      go("DIVU",    OP_DIVU,   32'd100,       32'd7,         32'd14,        34);
      go("REMU",    OP_REMU,   32'd100,       32'd7,         32'd2,         34);
      go("DIVU0",   OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      go("REM0",    OP_REM,    32'd5,         32'd0,         32'd5,         1);
      go("DIVOVF",  OP_DIV,    MIN_NEG,       32'hFFFF_FFFF, MIN_NEG,       1);
      go("REMOVF",  OP_REM,    MIN_NEG,       32'hFFFF_FFFF, 32'h0,         1);
      idle(3);

      go("B2B MUL", OP_MUL,    32'd3,         32'd4,         32'd12,        34);
      go("B2B DIV", OP_DIV,    32'd12,        32'd4,         32'd3,         34);
      idle(2);

      // Flush on the tenth MUL_RUN cycle
      @(posedge clk); #1;
      bus.START = 1'b1; bus.ALU_OP = OP_MUL; bus.DATA1 = 32'd9; bus.DATA2 = 32'd9;
      repeat (10) @(posedge clk);
      #1 bus.FLUSH = 1'b1;
      @(negedge clk);
      chk("flush stall", 32'(bus.STALL), 32'h0);
      @(posedge clk); #1;
      bus.FLUSH = 1'b0; bus.START = 1'b0; bus.ALU_OP = OP_ADD;
      @(negedge clk);
      chk("flush busy", 32'(bus.BUSY), 32'h0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.RESULT_VALID) seen++;
      end
      chk("flush no valid", 32'(seen), 32'h0);
      chk("flush result kept", bus.RESULT, 32'd3);

      // A non-M op must never stall
      @(posedge clk); #1;
      bus.START = 1'b1; bus.ALU_OP = OP_ADD; bus.DATA1 = 32'd1; bus.DATA2 = 32'd2;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.STALL || bus.BUSY) seen++;
      end
      chk("add no stall", 32'(seen), 32'h0);
      idle(1);

      // Asynchronous reset mid DIV_RUN, with the counter at 12
      @(posedge clk); #1;
      bus.START = 1'b1; bus.ALU_OP = OP_DIV; bus.DATA1 = 32'd1000; bus.DATA2 = 32'd3;
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0; bus.START = 1'b0; bus.ALU_OP = OP_ADD;
      #1;
      chk("areset stall", 32'(bus.STALL), 32'h0);
      chk("areset busy", 32'(bus.BUSY), 32'h0);
      chk("areset valid", 32'(bus.RESULT_VALID), 32'h0);
      chk("areset result", bus.RESULT, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      go("post-reset MUL", OP_MUL, 32'd6, 32'd7, 32'd42, 34);
      idle(3);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
